wb_port_responder: RTL and testbench

//  Responder end of the wb_port internal access interface (acc/we/adr/dat/sel -> ack/adr/dat).

---
 rtl/wb_port_pkg.sv | 31 +++
 rtl/wb_port_responder.sv | 137 +++++++++++++
 tb/tb_wb_port_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_pkg.sv
// Shared definitions for the wb_port internal access interface and its responders.
// Holds the Wishbone cycle-type and burst-type codes plus the common FSM encoding.
package wb_port_pkg;

  localparam logic [2:0] CtiClassic  = 3'b000;
  localparam logic [2:0] CtiIncBurst = 3'b010;
  localparam logic [2:0] CtiEndBurst = 3'b111;

  localparam logic [1:0] BteLinear = 2'b00;
  localparam logic [1:0] BteWrap4  = 2'b01;
  localparam logic [1:0] BteWrap8  = 2'b10;
  localparam logic [1:0] BteWrap16 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrSingle,
    StTurn
  } wb_port_state_e;

  // Wrap burst type matching a refill line of 2**buf_width words.
  function automatic logic [1:0] wrap_bte(int unsigned buf_width);
    case (buf_width)
      2:       return BteWrap4;
      3:       return BteWrap8;
      4:       return BteWrap16;
      default: return BteLinear;
    endcase
  endfunction

endpackage

// File: rtl/wb_port_responder.sv
// Wishbone B3 back end for wb_port: writes go out as single classic cycles,
// reads as one wrapped incrementing burst that refills a whole line.
module wb_port_responder
  import wb_port_pkg::*;
#(
  parameter int unsigned BUF_WIDTH = 3
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic        err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  if (BUF_WIDTH < 2 || BUF_WIDTH > 4) begin : gen_bad_buf_width
    $error("wb_port_responder: BUF_WIDTH must be 2, 3 or 4");
  end

  localparam int unsigned      Beats    = 2 ** BUF_WIDTH;
  localparam logic [BUF_WIDTH:0] CntEnd  = (BUF_WIDTH + 1)'(Beats - 2);
  localparam logic [BUF_WIDTH:0] CntLast = (BUF_WIDTH + 1)'(Beats - 1);
  localparam logic [31:0]      LineMask = ((32'd1 << (BUF_WIDTH + 2)) - 32'd1) & ~32'd3;
  localparam logic [1:0]       BteLine  = wrap_bte(BUF_WIDTH);

  // Next word address inside the refill line; bits above the line never move.
  function automatic logic [31:0] wrap_incr(logic [31:0] adr);
    return (adr & ~LineMask) | ((adr + 32'd4) & LineMask);
  endfunction

  wb_port_state_e       state_q;
  logic [BUF_WIDTH:0]   cnt_q;
  logic                 beat_done;

  assign beat_done = wbm_ack_i | wbm_err_i;

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ack_o     <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      err_o     <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_cti_o <= CtiClassic;
      wbm_bte_o <= BteLinear;
    end else begin
      ack_o <= 1'b0;
      if (wbm_err_i && wbm_cyc_o) begin
        err_o <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (acc_i) begin
            wbm_adr_o <= adr_i & ~32'd3;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cnt_q     <= '0;
            if (we_i) begin
              wbm_dat_o <= dat_i;
              wbm_sel_o <= sel_i;
              wbm_we_o  <= 1'b1;
              wbm_cti_o <= CtiClassic;
              wbm_bte_o <= BteLinear;
              state_q   <= StWrSingle;
            end else begin
              wbm_sel_o <= 4'hF;
              wbm_we_o  <= 1'b0;
              wbm_cti_o <= CtiIncBurst;
              wbm_bte_o <= BteLine;
              state_q   <= StRdBurst;
            end
          end
        end

        StRdBurst: begin
          if (beat_done) begin
            ack_o     <= 1'b1;
            dat_o     <= wbm_dat_i;
            adr_o     <= wbm_adr_o;
            wbm_adr_o <= wrap_incr(wbm_adr_o);
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_cti_o <= CtiClassic;
              state_q   <= StTurn;
            end else if (cnt_q == CntEnd) begin
              // Flag the upcoming beat as the last one of the burst.
              wbm_cti_o <= CtiEndBurst;
            end
          end
        end

        StWrSingle: begin
          if (beat_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            ack_o     <= 1'b1;
            adr_o     <= wbm_adr_o;
            state_q   <= StTurn;
          end
        end

        // The initiator still holds acc_i here, so it is deliberately ignored.
        StTurn: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_responder.sv
// Directed bench for wb_port_responder with a wait-state capable Wishbone slave model.
// Slave memory returns word == address; table rows carry hand-computed expectations.
module tb_wb_port_responder;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst_n;
  logic        acc_i, we_i;
  logic [31:0] adr_i, dat_i;
  logic [3:0]  sel_i;
  logic        ack_o, err_o;
  logic [31:0] adr_o, dat_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;

  wb_port_responder #(.BUF_WIDTH(3)) dut (
    .sdram_clk   (sdram_clk),
    .sdram_rst_n (sdram_rst_n),
    .acc_i       (acc_i),
    .we_i        (we_i),
    .adr_i       (adr_i),
    .dat_i       (dat_i),
    .sel_i       (sel_i),
    .ack_o       (ack_o),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .err_o       (err_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_cti_o   (wbm_cti_o),
    .wbm_bte_o   (wbm_bte_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i)
  );

  always #5 sdram_clk = ~sdram_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave model: decides ack/err at each falling edge for the next rising edge.
  int          sl_wait_mode = 0;   // <0 means random 0..5 per beat
  int          sl_err_beat  = -1;
  int          sl_beats     = 0;
  int          wb_cycles    = 0;
  logic [31:0] sl_adr  [16];
  logic [2:0]  sl_cti  [16];
  logic [1:0]  sl_bte  [16];
  logic        sl_we   [16];
  logic [31:0] sl_wdat [16];
  logic [3:0]  sl_sel  [16];

  initial begin
    int  wait_left;
    bit  need_new;
    bit  prev_cyc;
    wait_left = 0;
    need_new  = 1'b1;
    prev_cyc  = 1'b0;
    forever begin
      @(negedge sdram_clk);
      if (wbm_cyc_o && !prev_cyc) begin
        wb_cycles++;
        sl_beats = 0;
      end
      prev_cyc = wbm_cyc_o;
      if (!(wbm_cyc_o && wbm_stb_o)) begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        need_new  = 1'b1;
      end else begin
        if (need_new) begin
          wait_left = (sl_wait_mode < 0) ? int'($urandom_range(0, 5)) : sl_wait_mode;
          need_new  = 1'b0;
        end
        if (wait_left == 0) begin
          if (sl_beats < 16) begin
            sl_adr[sl_beats]  = wbm_adr_o;
            sl_cti[sl_beats]  = wbm_cti_o;
            sl_bte[sl_beats]  = wbm_bte_o;
            sl_we[sl_beats]   = wbm_we_o;
            sl_wdat[sl_beats] = wbm_dat_o;
            sl_sel[sl_beats]  = wbm_sel_o;
          end
          wbm_ack_i = (sl_beats != sl_err_beat);
          wbm_err_i = (sl_beats == sl_err_beat);
          wbm_dat_i = wbm_adr_o;
          sl_beats++;
          need_new = 1'b1;
        end else begin
          wait_left--;
          wbm_ack_i = 1'b0;
          wbm_err_i = 1'b0;
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    int          err_beat;
    int          exp_acks;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [1:0]  exp_bte;
    logic        exp_err;
  } txn_vec_t;

  // Expected beat address: 32-byte line, wrap via modulo.
  function automatic logic [31:0] exp_beat_adr(input logic [31:0] adr, input int k);
    logic [31:0] off;
    off = ((adr & 32'h1C) + 32'(4 * k)) % 32;
    return (adr & ~32'h1F) | off;
  endfunction

  logic [31:0] prev_dat_exp = '0;

  task automatic run_txn(input txn_vec_t v);
    logic [31:0] a_adr [16];
    logic [31:0] a_dat [16];
    int          n_acks;
    int          start_cycles;
    bit          done;
    n_acks       = 0;
    done         = 1'b0;
    sl_wait_mode = v.waits;
    sl_err_beat  = v.err_beat;
    @(negedge sdram_clk);
    start_cycles = wb_cycles;
    acc_i = 1'b1;
    we_i  = v.we;
    adr_i = v.adr;
    dat_i = v.dat;
    sel_i = v.sel;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge sdram_clk);
      if (ack_o) begin
        if (n_acks < 16) begin
          a_adr[n_acks] = adr_o;
          a_dat[n_acks] = dat_o;
        end
        n_acks++;
      end
      if (n_acks >= v.exp_acks) done = 1'b1;
    end
    check({v.name, " completes"}, 32'(done), 32'd1);
    // acc_i stays high across the TURN cycle, as wb_port does.
    @(negedge sdram_clk);
    check({v.name, " no ack after final"}, 32'(ack_o), 32'd0);
    acc_i = 1'b0;
    we_i  = 1'b0;
    @(negedge sdram_clk);
    check({v.name, " cyc idle after turn"}, 32'(wbm_cyc_o), 32'd0);
    @(negedge sdram_clk);
    check({v.name, " one wb cycle"}, 32'(wb_cycles - start_cycles), 32'd1);
    check({v.name, " ack count"}, 32'(n_acks), 32'(v.exp_acks));
    if (!done || n_acks != v.exp_acks) return;
    check({v.name, " first adr_o"}, a_adr[0], v.exp_first);
    check({v.name, " last adr_o"}, a_adr[v.exp_acks-1], v.exp_last);
    for (int k = 0; k < v.exp_acks; k++) begin
      check($sformatf("%s adr_o[%0d]", v.name, k), a_adr[k],
            v.we ? (v.adr & ~32'd3) : exp_beat_adr(v.adr, k));
      check($sformatf("%s wbm_adr[%0d]", v.name, k), sl_adr[k],
            v.we ? (v.adr & ~32'd3) : exp_beat_adr(v.adr, k));
      check($sformatf("%s wbm_we[%0d]", v.name, k), 32'(sl_we[k]), 32'(v.we));
      check($sformatf("%s wbm_bte[%0d]", v.name, k), 32'(sl_bte[k]), 32'(v.exp_bte));
      if (v.we) begin
        check({v.name, " dat_o held"}, a_dat[k], prev_dat_exp);
        check({v.name, " wbm_dat"}, sl_wdat[k], v.dat);
        check({v.name, " wbm_sel"}, 32'(sl_sel[k]), 32'(v.sel));
        check({v.name, " wbm_cti"}, 32'(sl_cti[k]), 32'b000);
      end else begin
        check($sformatf("%s dat_o[%0d]", v.name, k), a_dat[k], exp_beat_adr(v.adr, k));
        check($sformatf("%s wbm_cti[%0d]", v.name, k), 32'(sl_cti[k]),
              (k == v.exp_acks - 1) ? 32'b111 : 32'b010);
      end
    end
    if (!v.we) prev_dat_exp = exp_beat_adr(v.adr, v.exp_acks - 1);
    check({v.name, " err_o"}, 32'(err_o), 32'(v.exp_err));
  endtask

  txn_vec_t vecs [7];

  initial begin
    int  n_acks;
    bit  hit;
    vecs[0] = '{name: "wr_cafe", we: 1'b1, adr: 32'h0000_0100, dat: 32'hCAFE_F00D, sel: 4'hF,
                waits: 2, err_beat: -1, exp_acks: 1, exp_first: 32'h100, exp_last: 32'h100,
                exp_bte: 2'b00, exp_err: 1'b0};
    vecs[1] = '{name: "rd_214", we: 1'b0, adr: 32'h0000_0214, dat: 32'h0, sel: 4'h0,
                waits: 0, err_beat: -1, exp_acks: 8, exp_first: 32'h214, exp_last: 32'h210,
                exp_bte: 2'b10, exp_err: 1'b0};
    vecs[2] = '{name: "rd_rand", we: 1'b0, adr: 32'h0000_03F8, dat: 32'h0, sel: 4'h0,
                waits: -1, err_beat: -1, exp_acks: 8, exp_first: 32'h3F8, exp_last: 32'h3F4,
                exp_bte: 2'b10, exp_err: 1'b0};
    vecs[3] = '{name: "wr_unal", we: 1'b1, adr: 32'h0000_1003, dat: 32'h1234_5678, sel: 4'b0101,
                waits: 0, err_beat: -1, exp_acks: 1, exp_first: 32'h1000, exp_last: 32'h1000,
                exp_bte: 2'b00, exp_err: 1'b0};
    vecs[4] = '{name: "rd_zero", we: 1'b0, adr: 32'h0000_0000, dat: 32'h0, sel: 4'h0,
                waits: 1, err_beat: -1, exp_acks: 8, exp_first: 32'h0, exp_last: 32'h1C,
                exp_bte: 2'b10, exp_err: 1'b0};
    vecs[5] = '{name: "rd_err", we: 1'b0, adr: 32'hFFFF_FFE4, dat: 32'h0, sel: 4'h0,
                waits: 0, err_beat: 2, exp_acks: 8, exp_first: 32'hFFFF_FFE4,
                exp_last: 32'hFFFF_FFE0, exp_bte: 2'b10, exp_err: 1'b1};
    vecs[6] = '{name: "wr_after_err", we: 1'b1, adr: 32'h000A_BCD0, dat: 32'hDEAD_BEEF,
                sel: 4'b1000, waits: 3, err_beat: -1, exp_acks: 1, exp_first: 32'hA_BCD0,
                exp_last: 32'hA_BCD0, exp_bte: 2'b00, exp_err: 1'b1};

    sdram_rst_n = 1'b0;
    acc_i = 1'b0;
    we_i  = 1'b0;
    adr_i = '0;
    dat_i = '0;
    sel_i = '0;
    repeat (2) @(negedge sdram_clk);
    check("reset ack_o", 32'(ack_o), 32'd0);
    check("reset err_o", 32'(err_o), 32'd0);
    check("reset cyc/stb/we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    check("reset wbm_adr", wbm_adr_o, 32'd0);
    check("reset cti/bte/sel", {23'd0, wbm_cti_o, wbm_bte_o, wbm_sel_o}, 32'd0);
    check("reset adr_o", adr_o, 32'd0);
    check("reset dat_o", dat_o, 32'd0);
    sdram_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset in the middle of a burst, after four beats.
    sl_wait_mode = 0;
    sl_err_beat  = -1;
    @(negedge sdram_clk);
    acc_i  = 1'b1;
    we_i   = 1'b0;
    adr_i  = 32'h40;
    n_acks = 0;
    hit    = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge sdram_clk);
      if (ack_o) n_acks++;
      if (n_acks == 4) hit = 1'b1;
    end
    check("rst_mid reached beat 4", 32'(hit), 32'd1);
    sdram_rst_n = 1'b0;
    #1;
    check("rst_mid cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_mid stb", 32'(wbm_stb_o), 32'd0);
    check("rst_mid ack_o", 32'(ack_o), 32'd0);
    check("rst_mid err_o cleared", 32'(err_o), 32'd0);
    acc_i = 1'b0;
    repeat (2) begin
      @(negedge sdram_clk);
      check("rst_mid quiet ack_o", 32'(ack_o), 32'd0);
    end
    sdram_rst_n = 1'b1;
    @(negedge sdram_clk);
    check("rst_mid idle after release", 32'(wbm_cyc_o), 32'd0);
    run_txn('{name: "rd_after_rst", we: 1'b0, adr: 32'h0, dat: 32'h0, sel: 4'h0, waits: 0,
              err_beat: -1, exp_acks: 8, exp_first: 32'h0, exp_last: 32'h1C, exp_bte: 2'b10,
              exp_err: 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
